// File: rtl/race_timer.sv
// rtl/race_timer.sv - race timing, lap detection and finish/timeout flagging
module race_timer #(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter int unsigned NUM_LAPS    = 3,
  parameter int unsigned MIN_LAP_CS  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        lap_in,
  output logic [19:0] race_time,
  output logic [19:0] last_lap,
  output logic [19:0] best_lap,
  output logic [2:0]  lap_cnt,
  output logic        new_best,
  output logic        is_game_end,
  output logic        timeout
);

  localparam int unsigned PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [19:0] BCD_MAX   = 20'h95999;
  localparam logic [2:0]  LAPS      = 3'(NUM_LAPS);
  localparam logic [15:0] MIN_CS    = 16'(MIN_LAP_CS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETTING   = 3'd1;
  localparam logic [2:0] S_COUNTDOWN = 3'd3;
  localparam logic [2:0] S_RACING    = 3'd4;
  localparam logic [2:0] S_PAUSE     = 3'd5;

  logic [PW-1:0] presc_q, presc_d;
  logic          lap_in_q, lap_in_d;
  logic          lap_dly_q, lap_dly_d;
  logic [19:0]   race_q, race_d;
  logic [19:0]   lap_tmr_q, lap_tmr_d;
  logic [15:0]   lap_cs_q, lap_cs_d;
  logic [19:0]   last_q, last_d;
  logic [19:0]   best_q, best_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          new_best_q, new_best_d;
  logic          end_q, end_d;
  logic          timeout_q, timeout_d;
  logic          tick;
  logic          lap_edge;

  // BCD {min, sec10, sec1, cs10, cs1} increment, saturating at 9:59.99
  function automatic logic [19:0] bcd_inc(input logic [19:0] t);
    logic [19:0] r;
    r = t;
    if (t == BCD_MAX) begin
      r = BCD_MAX;
    end else if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd9) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            r[15:12] = t[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
            r[19:16] = t[19:16] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // Next-state: clear in pre-race states, count/lap in RACING, hold otherwise
  always_comb begin
    presc_d    = presc_q;
    lap_in_d   = lap_in;
    lap_dly_d  = lap_in_q;
    race_d     = race_q;
    lap_tmr_d  = lap_tmr_q;
    lap_cs_d   = lap_cs_q;
    last_d     = last_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    new_best_d = 1'b0;
    end_d      = end_q;
    timeout_d  = timeout_q;
    tick       = 1'b0;
    lap_edge   = lap_in_q & ~lap_dly_q;
    case (state)
      S_IDLE, S_SETTING, S_COUNTDOWN: begin
        presc_d   = '0;
        race_d    = '0;
        lap_tmr_d = '0;
        lap_cs_d  = '0;
        last_d    = '0;
        best_d    = BCD_MAX;
        cnt_d     = '0;
        end_d     = 1'b0;
        timeout_d = 1'b0;
      end
      S_RACING: begin
        if (!end_q) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
          if (tick) begin
            if (race_q == BCD_MAX) begin
              timeout_d = 1'b1;
              end_d     = 1'b1;
            end else begin
              race_d = bcd_inc(race_q);
            end
            lap_tmr_d = bcd_inc(lap_tmr_q);
            if (lap_cs_q != 16'hFFFF) lap_cs_d = lap_cs_q + 16'd1;
          end
          // A qualifying lap edge overrides the lap timer's tick
          if (lap_edge && (cnt_q < LAPS) && (lap_cs_q >= MIN_CS)) begin
            last_d    = lap_tmr_q;
            cnt_d     = cnt_q + 3'd1;
            lap_tmr_d = '0;
            lap_cs_d  = '0;
            if (lap_tmr_q < best_q) begin
              best_d     = lap_tmr_q;
              new_best_d = 1'b1;
            end
            if (cnt_q + 3'd1 == LAPS) end_d = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        // everything holds; prescaler resumes from where it stopped
      end
      default: begin
        // FINISH and undefined codes hold
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      lap_in_q   <= 1'b0;
      lap_dly_q  <= 1'b0;
      race_q     <= '0;
      lap_tmr_q  <= '0;
      lap_cs_q   <= '0;
      last_q     <= '0;
      best_q     <= BCD_MAX;
      cnt_q      <= '0;
      new_best_q <= 1'b0;
      end_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      lap_in_q   <= lap_in_d;
      lap_dly_q  <= lap_dly_d;
      race_q     <= race_d;
      lap_tmr_q  <= lap_tmr_d;
      lap_cs_q   <= lap_cs_d;
      last_q     <= last_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
      new_best_q <= new_best_d;
      end_q      <= end_d;
      timeout_q  <= timeout_d;
    end
  end

  assign race_time   = race_q;
  assign last_lap    = last_q;
  assign best_lap    = best_q;
  assign lap_cnt     = cnt_q;
  assign new_best    = new_best_q;
  assign is_game_end = end_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_race_timer.sv
// tb/tb_race_timer.sv - scoreboard bench for race_timer
module tb_race_timer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RACING = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  typedef struct packed {
    logic [19:0] last;
    logic [19:0] best;
    logic [2:0]  cnt;
    logic        nb;
  } lap_exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  state, state_t;
  logic        lap_in, lap_in_t;
  logic [19:0] race_time, last_lap, best_lap;
  logic [2:0]  lap_cnt;
  logic        new_best, is_game_end, timeout;
  logic [19:0] race_time_t, last_lap_t, best_lap_t;
  logic [2:0]  lap_cnt_t;
  logic        new_best_t, is_game_end_t, timeout_t;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;
  lap_exp_t lap_q[$];

  race_timer #(.TICK_CYCLES(4), .NUM_LAPS(3), .MIN_LAP_CS(2)) dut (
    .clk(clk), .rst(rst), .state(state), .lap_in(lap_in),
    .race_time(race_time), .last_lap(last_lap), .best_lap(best_lap),
    .lap_cnt(lap_cnt), .new_best(new_best), .is_game_end(is_game_end),
    .timeout(timeout)
  );

  race_timer #(.TICK_CYCLES(1), .NUM_LAPS(3), .MIN_LAP_CS(2)) dut_t (
    .clk(clk), .rst(rst), .state(state_t), .lap_in(lap_in_t),
    .race_time(race_time_t), .last_lap(last_lap_t), .best_lap(best_lap_t),
    .lap_cnt(lap_cnt_t), .new_best(new_best_t), .is_game_end(is_game_end_t),
    .timeout(timeout_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int n);
    while (ecount < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0; state = S_IDLE; lap_in = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_race();
    state  = S_RACING;
    ecount = 0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (race_time !== 20'h0) begin failures++; $display("FAIL reset_race_time got=%h exp=%h", race_time, 20'h0); end
    checks++; if (last_lap !== 20'h0) begin failures++; $display("FAIL reset_last_lap got=%h exp=%h", last_lap, 20'h0); end
    checks++; if (best_lap !== 20'h95999) begin failures++; $display("FAIL reset_best_lap got=%h exp=%h", best_lap, 20'h95999); end
    checks++; if (lap_cnt !== 3'd0) begin failures++; $display("FAIL reset_lap_cnt got=%0d exp=0", lap_cnt); end
    checks++; if ({new_best, is_game_end, timeout} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {new_best, is_game_end, timeout}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_reset();
    start_race();
    run_to(39);
    checks++; if (race_time !== 20'h00009) begin failures++; $display("FAIL basic_39 got=%h exp=%h", race_time, 20'h00009); end
    run_to(40);
    checks++; if (race_time !== 20'h00010) begin failures++; $display("FAIL basic_race_time got=%h exp=%h", race_time, 20'h00010); end
    checks++; if (lap_cnt !== 3'd0) begin failures++; $display("FAIL basic_lap_cnt got=%0d exp=0", lap_cnt); end
    checks++; if ({is_game_end, timeout} !== 2'b00) begin failures++; $display("FAIL basic_end got=%b exp=00", {is_game_end, timeout}); end
  endtask

  task automatic test_pause();
    do_reset();
    start_race();
    run_to(22);
    state  = S_PAUSE;
    lap_in = 1'b1;
    run_to(122);
    checks++; if (race_time !== 20'h00005) begin failures++; $display("FAIL pause_hold got=%h exp=%h", race_time, 20'h00005); end
    state = S_RACING;
    run_to(140);
    checks++; if (race_time !== 20'h00010) begin failures++; $display("FAIL pause_resume got=%h exp=%h", race_time, 20'h00010); end
    checks++; if (lap_cnt !== 3'd0) begin failures++; $display("FAIL pause_level_edge got=%0d exp=0", lap_cnt); end
    lap_in = 1'b0;
  endtask

  task automatic test_laps();
    int upd [3];
    lap_exp_t tab [3];
    lap_exp_t e;
    logic [2:0] prev;
    int n;
    upd[0] = 21; upd[1] = 33; upd[2] = 49;
    tab[0] = '{last: 20'h00005, best: 20'h00005, cnt: 3'd1, nb: 1'b1};
    tab[1] = '{last: 20'h00003, best: 20'h00003, cnt: 3'd2, nb: 1'b1};
    tab[2] = '{last: 20'h00004, best: 20'h00003, cnt: 3'd3, nb: 1'b0};
    do_reset();
    start_race();
    for (int i = 0; i < 3; i++) begin
      run_to(upd[i] - 2);
      lap_q.push_back(tab[i]);
      prev = lap_cnt; lap_in = 1'b1; n = 0;
      while (lap_cnt === prev && n < 8) begin step(); n++; end
      e = lap_q.pop_front();
      checks++; if (n != 2) begin failures++; $display("FAIL laps_latency lap=%0d got=%0d exp=2", i, n); end
      checks++; if (last_lap !== e.last) begin failures++; $display("FAIL laps_last lap=%0d got=%h exp=%h", i, last_lap, e.last); end
      checks++; if (best_lap !== e.best) begin failures++; $display("FAIL laps_best lap=%0d got=%h exp=%h", i, best_lap, e.best); end
      checks++; if (lap_cnt !== e.cnt) begin failures++; $display("FAIL laps_cnt lap=%0d got=%0d exp=%0d", i, lap_cnt, e.cnt); end
      checks++; if (new_best !== e.nb) begin failures++; $display("FAIL laps_new_best lap=%0d got=%b exp=%b", i, new_best, e.nb); end
      checks++; if (is_game_end !== (i == 2)) begin failures++; $display("FAIL laps_end lap=%0d got=%b exp=%b", i, is_game_end, (i == 2)); end
      step();
      lap_in = 1'b0;
      checks++; if (new_best !== 1'b0) begin failures++; $display("FAIL laps_pulse lap=%0d got=%b exp=0", i, new_best); end
    end
    checks++; if (race_time !== 20'h00012) begin failures++; $display("FAIL laps_race_time got=%h exp=%h", race_time, 20'h00012); end
    run_to(55);
    lap_in = 1'b1;
    repeat (6) step();
    lap_in = 1'b0;
    checks++; if (lap_cnt !== 3'd3) begin failures++; $display("FAIL laps_fourth got=%0d exp=3", lap_cnt); end
    checks++; if (race_time !== 20'h00012) begin failures++; $display("FAIL laps_freeze got=%h exp=%h", race_time, 20'h00012); end
  endtask

  task automatic test_finish_clear();
    state = S_FINISH;
    repeat (10) step();
    checks++; if ({race_time, last_lap, best_lap} !== {20'h00012, 20'h00004, 20'h00003}) begin failures++; $display("FAIL finish_hold got=%h/%h/%h exp=00012/00004/00003", race_time, last_lap, best_lap); end
    checks++; if ({lap_cnt, is_game_end} !== {3'd3, 1'b1}) begin failures++; $display("FAIL finish_flags got=%0d/%b exp=3/1", lap_cnt, is_game_end); end
    state = S_IDLE;
    step();
    checks++; if ({race_time, last_lap, best_lap} !== {20'h0, 20'h0, 20'h95999}) begin failures++; $display("FAIL idle_clear_times got=%h/%h/%h exp=00000/00000/95999", race_time, last_lap, best_lap); end
    checks++; if ({lap_cnt, new_best, is_game_end, timeout} !== 6'b0) begin failures++; $display("FAIL idle_clear_flags got=%b exp=000000", {lap_cnt, new_best, is_game_end, timeout}); end
    start_race();
    run_to(10);
    checks++; if (race_time !== 20'h00002) begin failures++; $display("FAIL prereset_race got=%h exp=%h", race_time, 20'h00002); end
    #2 rst = 1'b0;
    #1;
    checks++; if (race_time !== 20'h0) begin failures++; $display("FAIL async_reset_race got=%h exp=%h", race_time, 20'h0); end
    checks++; if ({best_lap, lap_cnt} !== {20'h95999, 3'd0}) begin failures++; $display("FAIL async_reset_lap got=%h/%0d exp=95999/0", best_lap, lap_cnt); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_lap_rules();
    int upd [2];
    lap_exp_t tab [2];
    lap_exp_t e;
    logic [2:0] prev;
    int n;
    upd[0] = 12; upd[1] = 21;
    tab[0] = '{last: 20'h00002, best: 20'h00002, cnt: 3'd1, nb: 1'b1};
    tab[1] = '{last: 20'h00002, best: 20'h00002, cnt: 3'd2, nb: 1'b0};
    do_reset();
    start_race();
    run_to(3);
    lap_in = 1'b1;
    run_to(7);
    checks++; if ({lap_cnt, last_lap} !== {3'd0, 20'h0}) begin failures++; $display("FAIL short_lap got=%0d/%h exp=0/00000", lap_cnt, last_lap); end
    lap_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_to(upd[i] - 2);
      lap_q.push_back(tab[i]);
      prev = lap_cnt; lap_in = 1'b1; n = 0;
      while (lap_cnt === prev && n < 8) begin step(); n++; end
      e = lap_q.pop_front();
      checks++; if (n != 2) begin failures++; $display("FAIL tick_lap_latency lap=%0d got=%0d exp=2", i, n); end
      checks++; if ({last_lap, best_lap} !== {e.last, e.best}) begin failures++; $display("FAIL tick_lap_times lap=%0d got=%h/%h exp=%h/%h", i, last_lap, best_lap, e.last, e.best); end
      checks++; if ({lap_cnt, new_best} !== {e.cnt, e.nb}) begin failures++; $display("FAIL tick_lap_flags lap=%0d got=%0d/%b exp=%0d/%b", i, lap_cnt, new_best, e.cnt, e.nb); end
      if (i == 0) begin
        checks++; if (race_time !== 20'h00003) begin failures++; $display("FAIL tick_lap_race got=%h exp=%h", race_time, 20'h00003); end
      end
      step();
      lap_in = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int n;
    state_t = S_RACING;
    n = 0;
    while (n < 59998) begin step(); n++; end
    checks++; if ({race_time_t, timeout_t} !== {20'h95998, 1'b0}) begin failures++; $display("FAIL timeout_pre got=%h/%b exp=95998/0", race_time_t, timeout_t); end
    step();
    checks++; if ({race_time_t, timeout_t, is_game_end_t} !== {20'h95999, 2'b00}) begin failures++; $display("FAIL timeout_max got=%h/%b/%b exp=95999/0/0", race_time_t, timeout_t, is_game_end_t); end
    step();
    checks++; if ({race_time_t, timeout_t, is_game_end_t} !== {20'h95999, 2'b11}) begin failures++; $display("FAIL timeout_set got=%h/%b/%b exp=95999/1/1", race_time_t, timeout_t, is_game_end_t); end
    repeat (3) step();
    checks++; if ({race_time_t, timeout_t, is_game_end_t} !== {20'h95999, 2'b11}) begin failures++; $display("FAIL timeout_hold got=%h/%b/%b exp=95999/1/1", race_time_t, timeout_t, is_game_end_t); end
    state_t = S_IDLE;
  endtask

  initial begin
    rst = 1'b0; state = S_IDLE; state_t = S_IDLE; lap_in = 1'b0; lap_in_t = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_laps();
    test_finish_clear();
    test_lap_rules();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/race_timer.md
Name: race_timer

Overview:
- Race timing and lap/finish detection stage; sits directly upstream of the game state encoder.
- Consumes the encoder's 3-bit `state` and a finish-line sensor.
- Produces `is_game_end`, which drives the encoder's RACING→FINISH transition.
- Also produces BCD race and lap times for the seven-segment and VGA display blocks.

Parameters:
- `TICK_CYCLES`, 1_000_000: clk cycles per centisecond tick (100 MHz clock).
- `NUM_LAPS`, 3: laps to finish; legal range 1..7.
- `MIN_LAP_CS`, 200: minimum valid lap time in centiseconds; sensor edges before this are ignored.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `state` input 3: game state from the encoder. Encoding: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6.
- `lap_in` input 1: finish-line sensor level, synchronous to `clk`.
- `race_time` output 20: total time, BCD {min, sec10, sec1, cs10, cs1}.
- `last_lap` output 20: BCD time of the most recent completed lap.
- `best_lap` output 20: BCD fastest completed lap.
- `lap_cnt` output 3: completed laps.
- `new_best` output 1: one-cycle pulse when `best_lap` updates.
- `is_game_end` output 1: race over (all laps done or timeout).
- `timeout` output 1: race time saturated.

Behaviour:
- Reset, asynchronous, `rst`=0:
  - `race_time`=0, `last_lap`=0, `best_lap`=20'h95999 (9:59.99), `lap_cnt`=0.
  - `new_best`=0, `is_game_end`=0, `timeout`=0.
  - Prescaler, lap timer, binary lap counter and edge register all cleared.
  - Reset mid-race returns every output to these values immediately.
- Clear group (IDLE, SETTING, COUNTDOWN): every cycle, all outputs and internal counters are forced to their reset values. This covers a restart from FINISH via IDLE.
- RACING, with `is_game_end`=0:
  - Prescaler counts 0..TICK_CYCLES-1; a tick is generated on wrap.
  - On a tick, `race_time` increments as BCD: cs1 wraps 9→0 into cs10, cs10 9→0 into sec1, sec1 9→0 into sec10, sec10 5→0 into min.
  - On the same tick, the lap timer (same BCD format) and the binary lap centisecond counter (16-bit, saturating) also increment.
- PAUSE: prescaler, `race_time`, lap timer and all outputs hold. Resume continues from the held prescaler value; no extra tick is generated.
- FINISH and undefined codes (2, 7): all outputs and counters hold.
- Lap edge detection:
  - `lap_in` is registered every cycle in all states; an edge is lap_in=1 with previous value 0.
  - An edge counts only if: state=RACING, `is_game_end`=0, `lap_cnt` < NUM_LAPS, and binary lap cs ≥ MIN_LAP_CS. All other edges are discarded.
  - A level held across PAUSE, or from COUNTDOWN into RACING, does not produce an edge.
- Valid lap edge, registered, effective next cycle:
  - `last_lap` ← lap timer value in the edge cycle (pre-tick).
  - `lap_cnt` += 1.
  - Lap timer and binary lap counter are cleared. A tick in the same cycle is dropped for the lap timer but still applied to `race_time`.
  - If that lap time < `best_lap` (unsigned 20-bit compare, valid on well-formed BCD): `best_lap` updates and `new_best` pulses high for 1 cycle.
- Finish: when `lap_cnt` reaches NUM_LAPS, `is_game_end` is set in the same registered update (visible the cycle after the final edge).
- Timeout:
  - When `race_time`=9:59.99 and a tick occurs, `race_time` stays saturated, and `timeout` and `is_game_end` are set on that same tick.
  - The lap timer saturates at 9:59.99 independently, without asserting `timeout`.
- Once `is_game_end`=1, all timers freeze even if `state` is still RACING or moves to PAUSE. `is_game_end` stays set until the clear group or reset; the encoder relies on it being level-held.
- Latency:
  - Tick → `race_time` update: 1 cycle.
  - Sensor edge → `lap_cnt`, `last_lap`, `new_best`: 2 cycles from `lap_in` rising (1 cycle for edge registration, 1 for the update).

Test Plan (TICK_CYCLES=4, MIN_LAP_CS=2, NUM_LAPS=3):
1. Reset low, then state=RACING for 40 cycles → `race_time`=20'h00010, `lap_cnt`=0, `is_game_end`=0.
2. RACING 20 cycles, PAUSE 100 cycles, RACING 20 cycles → `race_time`=20'h00010. `lap_in` held high across the pause → `lap_cnt` stays 0.
3. Lap edges at lap times 0.05, 0.03, 0.04 →
   - `last_lap` = 00005, 00003, 00004.
   - `best_lap`=00003; `new_best` pulses on laps 1 and 2 only.
   - `lap_cnt`=3; `is_game_end`=1 the cycle after the 3rd edge.
   - A 4th edge is ignored and `race_time` freezes.
4. Edge at lap time 0.01 (< MIN_LAP_CS) → ignored, `lap_cnt` unchanged. Edge coinciding with a tick → `race_time` advances, `last_lap` holds the pre-tick value, lap timer restarts at 0.
5. Preload to 9:59.98 (force or long run), RACING → next tick gives 20'h95999; following tick sets `timeout`=1 and `is_game_end`=1 with `race_time` held at 20'h95999.
6. After finish, state=FINISH 10 cycles (outputs held), then IDLE → all outputs return to reset values. `rst` low mid-race → immediate clear with no clock edge needed.
